// File: rtl/bldc_commutator_pkg.sv
// Shared types and lookup tables for the six-step BLDC commutator.
package bldc_commutator_pkg;

   localparam int unsigned DutyWidthDefault = 8;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StDeadtime = 3'd1,
      StDrive    = 3'd2,
      StBrake    = 3'd3,
      StFault    = 3'd4
   } bc_state_e;

   // One-hot phase masks, bit order {C,B,A}.
   typedef struct packed {
      logic [2:0] high;
      logic [2:0] low;
   } phase_sel_t;

   // 000 and 111 cannot occur on a healthy 120-degree hall arrangement.
   function automatic logic hall_is_valid(input logic [2:0] code);
      return (code != 3'b000) && (code != 3'b111);
   endfunction

   // Hall code to commutation step; reverse is the forward step shifted by half a turn.
   function automatic logic [2:0] hall_to_step(input logic [2:0] code, input logic reverse);
      logic [2:0] fwd;
      case (code)
         3'b001:  fwd = 3'd0;
         3'b011:  fwd = 3'd1;
         3'b010:  fwd = 3'd2;
         3'b110:  fwd = 3'd3;
         3'b100:  fwd = 3'd4;
         3'b101:  fwd = 3'd5;
         default: fwd = 3'd0;
      endcase
      if (!reverse) begin
         return fwd;
      end
      // Explicit mod 6 so the result never leaves 0..5.
      return (fwd >= 3'd3) ? (fwd - 3'd3) : (fwd + 3'd3);
   endfunction

   // Step to high-side / low-side phase; the remaining phase floats.
   function automatic phase_sel_t step_to_phases(input logic [2:0] s);
      phase_sel_t sel;
      case (s)
         3'd0:    begin sel.high = 3'b001; sel.low = 3'b010; end
         3'd1:    begin sel.high = 3'b001; sel.low = 3'b100; end
         3'd2:    begin sel.high = 3'b010; sel.low = 3'b100; end
         3'd3:    begin sel.high = 3'b010; sel.low = 3'b001; end
         3'd4:    begin sel.high = 3'b100; sel.low = 3'b001; end
         3'd5:    begin sel.high = 3'b100; sel.low = 3'b010; end
         default: begin sel.high = 3'b000; sel.low = 3'b000; end
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/bldc_commutator_hall_debounce.sv
// Hall input synchroniser and debouncer. A new code is accepted once it has been
// seen on DEBOUNCE_CYCLES consecutive synchronised samples; code_valid marks that
// at least one code has been accepted since reset.
module bldc_commutator_hall_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [2:0] hall,
   output logic [2:0] code,
   output logic       code_valid
);
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      cand_q, cand_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      code_q, code_d;
   logic            valid_q, valid_d;

   // Two-flop synchroniser for the asynchronous hall lines.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= hall;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive identical samples and accept on the last one.
   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = valid_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = CntW'(1);
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CntLast) begin
            code_d  = cand_q;
            valid_d = 1'b1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cand_q  <= 3'b000;
         cnt_q   <= '0;
         code_q  <= 3'b000;
         valid_q <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   assign code       = code_q;
   assign code_valid = valid_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: hall decode, dead-time sequencing,
// per-phase drive decode for three phase drivers, and stall detection.
module bldc_commutator
   import bldc_commutator_pkg::*;
#(
   parameter int unsigned DUTY_CYCLE_WIDTH = DutyWidthDefault,
   parameter int unsigned DEBOUNCE_CYCLES  = 4,
   parameter int unsigned DEADTIME_CYCLES  = 8,
   parameter int unsigned STALL_CYCLES     = 1048575
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          direction,
   input  logic                          brake,
   input  logic [DUTY_CYCLE_WIDTH-1:0]   duty_cycle,
   input  logic [2:0]                    hall,
   output logic [3*DUTY_CYCLE_WIDTH-1:0] phase_duty,
   output logic [2:0]                    phase_high_z,
   output logic [2:0]                    step,
   output logic                          hall_fault,
   output logic                          stall
);
   localparam int unsigned DtW    = $clog2(DEADTIME_CYCLES + 1);
   localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);
   localparam logic [DtW-1:0]    DtLast   = DtW'(DEADTIME_CYCLES - 1);
   localparam logic [StallW-1:0] StallMax = StallW'(STALL_CYCLES);

   logic [2:0]                  hall_code;
   logic                        hall_known;
   logic                        hall_ok, hall_bad;
   logic [2:0]                  hall_step;
   logic                        step_new;
   bc_state_e                   state_q, state_d;
   logic [2:0]                  step_q, step_d;
   logic [DtW-1:0]              dt_cnt_q, dt_cnt_d;
   logic [StallW-1:0]           stall_cnt_q, stall_cnt_d;
   logic                        stall_q, stall_d;
   logic [DUTY_CYCLE_WIDTH-1:0] duty_q;
   phase_sel_t                  sel;

   bldc_commutator_hall_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hall_debounce (
      .clock     (clock),
      .reset_n   (reset_n),
      .hall      (hall),
      .code      (hall_code),
      .code_valid(hall_known)
   );

   // Hall decode is ignored until the debouncer has produced its first code.
   assign hall_ok   = hall_known && hall_is_valid(hall_code);
   assign hall_bad  = hall_known && !hall_is_valid(hall_code);
   assign hall_step = hall_to_step(hall_code, direction);
   assign step_new  = hall_ok && (hall_step != step_q);

   // Next-state: enable, then invalid hall, then brake, then step change.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      dt_cnt_d    = dt_cnt_q;
      stall_cnt_d = '0;
      stall_d     = stall_q;
      if (!enable) begin
         state_d  = StIdle;
         dt_cnt_d = '0;
         stall_d  = 1'b0;
      end else if (hall_bad) begin
         state_d  = StFault;
         dt_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (hall_ok) begin
                  state_d  = StDeadtime;
                  step_d   = hall_step;
                  dt_cnt_d = '0;
               end
            end
            StDeadtime: begin
               if (step_new) begin
                  // Rotor moved again before the gap ended: restart it.
                  step_d   = hall_step;
                  dt_cnt_d = '0;
                  stall_d  = 1'b0;
               end else if (dt_cnt_q == DtLast) begin
                  state_d  = brake ? StBrake : StDrive;
                  dt_cnt_d = '0;
               end else begin
                  dt_cnt_d = dt_cnt_q + 1'b1;
               end
            end
            StDrive: begin
               if (brake) begin
                  state_d  = StDeadtime;
                  dt_cnt_d = '0;
               end else if (step_new) begin
                  state_d  = StDeadtime;
                  step_d   = hall_step;
                  dt_cnt_d = '0;
                  stall_d  = 1'b0;
               end else begin
                  stall_cnt_d = (stall_cnt_q == StallMax) ? StallMax : (stall_cnt_q + 1'b1);
                  if (stall_cnt_d == StallMax) begin
                     stall_d = 1'b1;
                  end
               end
            end
            StBrake: begin
               // Track the rotor so the first drive after release uses the live step.
               if (step_new) begin
                  step_d  = hall_step;
                  stall_d = 1'b0;
               end
               if (!brake) begin
                  state_d  = StDeadtime;
                  dt_cnt_d = '0;
               end
            end
            StFault: begin
               state_d = StFault;
            end
            default: begin
               state_d  = StIdle;
               dt_cnt_d = '0;
            end
         endcase
      end
   end

   // FSM, counters and registered duty command.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         step_q      <= 3'd0;
         dt_cnt_q    <= '0;
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
         duty_q      <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         dt_cnt_q    <= dt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         stall_q     <= stall_d;
         duty_q      <= duty_cycle;
      end
   end

   // Per-phase duty / high_z decode from state and step.
   always_comb begin
      phase_duty   = '0;
      phase_high_z = 3'b111;
      sel          = step_to_phases(step_q);
      unique case (state_q)
         StDrive: begin
            phase_high_z = ~(sel.high | sel.low);
            for (int i = 0; i < 3; i++) begin
               if (sel.high[i]) begin
                  phase_duty[i*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH] = duty_q;
               end
            end
         end
         StBrake: begin
            phase_high_z = 3'b000;
         end
         default: begin
            phase_high_z = 3'b111;
         end
      endcase
   end

   assign step       = step_q;
   assign stall      = stall_q;
   assign hall_fault = (state_q == StFault);

endmodule
